spi_responder: RTL and testbench

- 3-wire SPI target that terminates the same instruction/data frames the DAQ issues to the ADCs: a 16-bit instruction (R/Wb, W1:W0, A12:A0), MSB first, followed by data bytes.
- Bridges the serial frames onto a simple parallel register-file port.
- Used for loopback verification of the DAQ SPI path and for emulating ADC configuration registers on auxiliary boards.
- The design is fully synchronous to clk; sclk, csb and sdio are oversampled, and clk must be at least 8x sclk.

---
 rtl/spi_responder_pkg.sv | 32 +++
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_responder.sv | 204 ++++++++++++++++++++
 tb/tb_spi_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_responder_pkg.sv
// Shared definitions for the SPI register responder: FSM states, instruction fields, W codes.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package spi_responder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INSTR = 3'd1,
      ST_WDATA = 3'd2,
      ST_RDATA = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Instruction word layout: R/Wb, W1:W0, A12:A0, sent MSB first
   localparam int RW_BIT   = 15;
   localparam int W_MSB    = 14;
   localparam int W_LSB    = 13;
   localparam int ADDR_MSB = 12;

   // W code meaning "keep transferring bytes until csb rises"
   localparam logic [1:0] W_STREAM = 2'b11;

   // Bit-counter values at which the last rising edge of a field is seen
   localparam logic [3:0] INSTR_LAST_BIT = 4'd15;
   localparam logic [3:0] BYTE_LAST_BIT  = 4'd7;

   // Number of data bytes for a fixed-length frame (W=0..2 -> 1..3)
   function automatic logic [1:0] bytes_for_w(input logic [1:0] w);
      return w + 2'd1;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with selectable reset value and single-clk rise/fall pulses.
// Latency: o_q follows i_d after STAGES clk; edge pulses are usable on clk STAGES+1.
// Backpressure: none; free-running sampler.
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_q_d;

   // Shift the asynchronous input through the chain and keep one delayed copy for edge detection
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_sync <= {STAGES{RST_VAL}};
         r_q_d  <= RST_VAL;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
         r_q_d  <= r_sync[STAGES-1];
      end
   end

   assign o_q    = r_sync[STAGES-1];
   assign o_rise = r_sync[STAGES-1] & ~r_q_d;
   assign o_fall = ~r_sync[STAGES-1] & r_q_d;

endmodule

// File: rtl/spi_responder.sv
// 3-wire SPI target bridging 16-bit instruction + data-byte frames onto a parallel register port.
// Latency: sclk/csb edges act SYNC_STAGES+1 clk after the pin; reg_wr/reg_rd fire 1 clk after the deciding edge.
// Backpressure: none; reg_rdata must be valid the clk after reg_rd, clk must be >= 8x sclk.
module spi_responder
   import spi_responder_pkg::*;
#(
   parameter int ADDR_W      = 13,
   parameter int SYNC_STAGES = 2
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_sclk,
   input  logic              i_csb,
   input  logic              i_sdio,
   output logic              o_sdio,
   output logic              o_sdio_oe,
   output logic [ADDR_W-1:0] o_reg_addr,
   output logic [7:0]        o_reg_wdata,
   output logic              o_reg_wr,
   output logic              o_reg_rd,
   input  logic [7:0]        i_reg_rdata,
   output logic              o_busy,
   output logic              o_frame_err
);

   logic w_sclk_rise, w_sclk_fall, w_sclk_lvl;
   logic w_csb_rise, w_csb_fall, w_csb_lvl;
   logic w_sdio, w_sdio_rise, w_sdio_fall;
   logic w_unused;

   // csb resets to 0 so a csb already low when reset ends never looks like a frame start
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .i_clk(i_clk), .i_reset(i_reset), .i_d(i_sclk),
      .o_q(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_csb (
      .i_clk(i_clk), .i_reset(i_reset), .i_d(i_csb),
      .o_q(w_csb_lvl), .o_rise(w_csb_rise), .o_fall(w_csb_fall));

   // sdio shares the sclk delay, so its synchronized value lines up with the sclk rise pulse
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdio (
      .i_clk(i_clk), .i_reset(i_reset), .i_d(i_sdio),
      .o_q(w_sdio), .o_rise(w_sdio_rise), .o_fall(w_sdio_fall));

   assign w_unused = ^{w_sclk_lvl, w_csb_lvl, w_sdio_rise, w_sdio_fall};

   state_t            r_state, w_state_nxt;
   logic [3:0]        r_bit_cnt;
   logic [14:0]       r_shift;
   logic [1:0]        r_w;
   logic [1:0]        r_bytes_left;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_wdata;
   logic              r_wr, r_rd, r_load, r_last;
   logic              r_sdio, r_sdio_oe, r_frame_err;
   logic              w_busy;

   logic [15:0] w_instr;
   logic        w_in_frame, w_abort, w_instr_done, w_byte_done, w_more;

   // Shift register plus the bit arriving now: the full instruction on its 16th edge, the byte on its 8th
   assign w_instr      = {r_shift, w_sdio};
   assign w_in_frame   = (r_state == ST_INSTR) || (r_state == ST_WDATA) || (r_state == ST_RDATA);
   assign w_abort      = w_in_frame && (r_bit_cnt != 4'd0);
   assign w_instr_done = (r_state == ST_INSTR) && w_sclk_rise && !w_csb_rise &&
                         (r_bit_cnt == INSTR_LAST_BIT);
   assign w_byte_done  = ((r_state == ST_WDATA) || (r_state == ST_RDATA)) && w_sclk_rise &&
                         !w_csb_rise && (r_bit_cnt == BYTE_LAST_BIT);
   assign w_more       = (r_w == W_STREAM) || (r_bytes_left != 2'd1);

   // State register
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state: csb rising always wins, otherwise advance on completed fields
   always_comb begin
      w_state_nxt = r_state;
      if ((r_state != ST_IDLE) && w_csb_rise) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (w_csb_fall) w_state_nxt = ST_INSTR;
            ST_INSTR: if (w_instr_done) w_state_nxt = w_instr[RW_BIT] ? ST_RDATA : ST_WDATA;
            ST_WDATA: if (w_byte_done && !w_more) w_state_nxt = ST_DONE;
            ST_RDATA: if (w_sclk_fall && r_last) w_state_nxt = ST_DONE;
            default:  w_state_nxt = r_state;
         endcase
      end
   end

   // Output decode from state
   always_comb begin
      w_busy = (r_state != ST_IDLE);
   end

   // Datapath: shifting, address/byte bookkeeping, strobes and sdio drive
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_bit_cnt    <= 4'd0;
         r_shift      <= 15'd0;
         r_w          <= 2'd0;
         r_bytes_left <= 2'd0;
         r_addr       <= '0;
         r_wdata      <= 8'd0;
         r_wr         <= 1'b0;
         r_rd         <= 1'b0;
         r_load       <= 1'b0;
         r_last       <= 1'b0;
         r_sdio       <= 1'b0;
         r_sdio_oe    <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_wr        <= 1'b0;
         r_rd        <= 1'b0;
         r_frame_err <= 1'b0;
         r_load      <= r_rd;
         // A write strobe has used the current address; step to the next one afterwards
         if (r_wr) r_addr <= r_addr - ADDR_W'(1);

         if ((r_state != ST_IDLE) && w_csb_rise) begin
            r_frame_err <= w_abort;
            r_bit_cnt   <= 4'd0;
            r_sdio_oe   <= 1'b0;
            r_sdio      <= 1'b0;
            r_last      <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_csb_fall) begin
                     r_bit_cnt <= 4'd0;
                     r_last    <= 1'b0;
                  end
               end
               ST_INSTR: begin
                  if (w_sclk_rise) begin
                     r_shift   <= w_instr[14:0];
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == INSTR_LAST_BIT) begin
                        r_addr       <= w_instr[ADDR_W-1:0];
                        r_w          <= w_instr[W_MSB:W_LSB];
                        r_bytes_left <= bytes_for_w(w_instr[W_MSB:W_LSB]);
                        r_rd         <= w_instr[RW_BIT];
                     end
                  end
               end
               ST_WDATA: begin
                  if (w_sclk_rise) begin
                     r_shift <= w_instr[14:0];
                     if (r_bit_cnt == BYTE_LAST_BIT) begin
                        r_bit_cnt    <= 4'd0;
                        r_wdata      <= w_instr[7:0];
                        r_wr         <= 1'b1;
                        r_bytes_left <= r_bytes_left - 2'd1;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                     end
                  end
               end
               ST_RDATA: begin
                  if (w_sclk_fall) begin
                     if (r_last) begin
                        r_sdio_oe <= 1'b0;
                        r_sdio    <= 1'b0;
                     end else begin
                        r_sdio_oe <= 1'b1;
                        r_sdio    <= r_shift[7];
                        r_shift   <= {r_shift[13:0], 1'b0};
                     end
                  end
                  if (w_sclk_rise) begin
                     if (r_bit_cnt == BYTE_LAST_BIT) begin
                        r_bit_cnt    <= 4'd0;
                        r_addr       <= r_addr - ADDR_W'(1);
                        r_bytes_left <= r_bytes_left - 2'd1;
                        if (w_more) r_rd   <= 1'b1;
                        else        r_last <= 1'b1;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                     end
                  end
               end
               default: begin
                  r_bit_cnt <= r_bit_cnt;
               end
            endcase
         end

         // Read data lands one clk after the reg_rd strobe, well before the next sclk fall
         if (r_load) r_shift <= {7'd0, i_reg_rdata};
      end
   end

   assign o_sdio      = r_sdio;
   assign o_sdio_oe   = r_sdio_oe;
   assign o_reg_addr  = r_addr;
   assign o_reg_wdata = r_wdata;
   assign o_reg_wr    = r_wr;
   assign o_reg_rd    = r_rd;
   assign o_busy      = w_busy;
   assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_responder.sv
// Randomized bench for spi_responder: bit-bangs SPI frames and compares strobes and sdio against a frame-level model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_spi_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sclk = 1'b0;
   logic        csb = 1'b1;
   logic        sdio = 1'b0;
   logic        sdio_o, sdio_oe;
   logic [12:0] reg_addr;
   logic [7:0]  reg_wdata;
   logic [7:0]  reg_rdata = 8'd0;
   logic        reg_wr, reg_rd, busy, frame_err;

   always #5 clk = ~clk;

   spi_responder #(.ADDR_W(13), .SYNC_STAGES(2)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_sclk(sclk), .i_csb(csb), .i_sdio(sdio),
      .o_sdio(sdio_o), .o_sdio_oe(sdio_oe), .o_reg_addr(reg_addr),
      .o_reg_wdata(reg_wdata), .o_reg_wr(reg_wr), .o_reg_rd(reg_rd),
      .i_reg_rdata(reg_rdata), .o_busy(busy), .o_frame_err(frame_err));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Register file contents the emulated target returns on reads
   logic [7:0] rmem [0:8191];

   always @(negedge clk) reg_rdata = rmem[reg_addr];

   // Monitor: sole writer of the observation queues and counters
   logic [20:0] wr_q [$];
   logic [12:0] rd_q [$];
   int          err_cnt = 0;
   int          oe_seen = 0;

   always @(negedge clk) begin
      if (reg_wr)    wr_q.push_back({reg_addr, reg_wdata});
      if (reg_rd)    rd_q.push_back(reg_addr);
      if (frame_err) err_cnt++;
      if (sdio_oe)   oe_seen++;
   end

   int         half = 6;
   logic [7:0] wdat [0:7];

   // One SPI bit in mode 0: drive sdio while sclk is low, sample sdio just before the rising edge
   task automatic bit_xfer(input logic d, output logic q, output logic qoe);
      sdio = d;
      repeat (half) @(negedge clk);
      q   = sdio_o;
      qoe = sdio_oe;
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
   endtask

   // Full frame: instruction, nbytes whole data bytes, then optionally abort_bits of a partial byte
   task automatic run_frame(input logic [15:0] instr, input int nbytes, input int abort_bits,
                            input string tag);
      logic        rw, q, qoe;
      logic [1:0]  wc;
      logic [12:0] a0, ea;
      logic [7:0]  got;
      logic [7:0]  rgot [0:7];
      int          nmax, nact, nrd, nloop, nb, exp_err, oe_bad;
      int          wr0, rd0, err0, oe0;

      rw   = instr[15];
      wc   = instr[14:13];
      a0   = instr[12:0];
      nmax = (wc == 2'b11) ? 1000 : int'(wc) + 1;
      nact = (nbytes < nmax) ? nbytes : nmax;
      nloop = nbytes + ((abort_bits > 0) ? 1 : 0);
      wr0 = wr_q.size(); rd0 = rd_q.size(); err0 = err_cnt; oe0 = oe_seen;
      oe_bad = 0;
      for (int b = 0; b < 8; b++) rgot[b] = 8'd0;

      half = $urandom_range(5, 8);
      csb  = 1'b0;
      sdio = 1'b0;
      repeat (half) @(negedge clk);
      check({tag, " busy_on"}, busy, 1);

      for (int i = 15; i >= 0; i--) bit_xfer(instr[i], q, qoe);
      for (int b = 0; b < nloop; b++) begin
         nb  = (b == nbytes) ? abort_bits : 8;
         got = 8'd0;
         for (int i = 0; i < nb; i++) begin
            bit_xfer(rw ? 1'b0 : wdat[b][7-i], q, qoe);
            got = {got[6:0], q};
            if (rw && (b < nact) && (qoe !== 1'b1)) oe_bad++;
         end
         if (b < 8) rgot[b] = got;
      end
      sdio = 1'b0;
      repeat (half) @(negedge clk);
      if (rw && (nbytes >= nmax) && (abort_bits == 0)) check({tag, " oe_off"}, sdio_oe, 0);

      csb = 1'b1;
      repeat (3) @(negedge clk);
      check({tag, " busy_off"}, busy, 0);
      check({tag, " oe_idle"}, sdio_oe, 0);
      repeat (2 * half) @(negedge clk);

      exp_err = ((abort_bits > 0) && (nbytes < nmax)) ? 1 : 0;
      check({tag, " frame_err"}, err_cnt - err0, exp_err);

      if (!rw) begin
         check({tag, " wr_cnt"}, wr_q.size() - wr0, nact);
         check({tag, " rd_cnt"}, rd_q.size() - rd0, 0);
         check({tag, " oe_wr"}, oe_seen - oe0, 0);
         for (int i = 0; i < nact; i++) begin
            ea = a0 - 13'(i);
            if (wr0 + i < wr_q.size())
               check({tag, " wr_ent"}, wr_q[wr0+i], {ea, wdat[i]});
         end
      end else begin
         nrd = (wc == 2'b11) ? nbytes + 1 : ((nbytes + 1 < nmax) ? nbytes + 1 : nmax);
         check({tag, " rd_cnt"}, rd_q.size() - rd0, nrd);
         check({tag, " wr_cnt"}, wr_q.size() - wr0, 0);
         check({tag, " oe_during"}, oe_bad, 0);
         for (int i = 0; i < nrd; i++) begin
            ea = a0 - 13'(i);
            if (rd0 + i < rd_q.size()) check({tag, " rd_addr"}, rd_q[rd0+i], ea);
         end
         for (int b = 0; b < nact; b++) begin
            ea = a0 - 13'(b);
            check({tag, " sdio_byte"}, rgot[b], rmem[ea]);
         end
      end
   endtask

   initial begin
      logic        q, qoe;
      logic [15:0] instr;
      int          wr0, rd0, err0, oe0, nb, ab;

      for (int i = 0; i < 8192; i++) rmem[i] = 8'($urandom);
      rmem[13'h014] = 8'h3C;

      repeat (4) @(negedge clk);
      check("rst busy", busy, 0);
      check("rst oe", sdio_oe, 0);
      check("rst wr", reg_wr, 0);
      check("rst rd", reg_rd, 0);
      check("rst err", frame_err, 0);
      check("rst addr", reg_addr, 0);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("idle busy", busy, 0);

      wdat[0] = 8'hA5;
      run_frame(16'h0014, 1, 0, "wr1");
      run_frame(16'h8014, 1, 0, "rd1");
      wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
      run_frame(16'h4002, 4, 0, "wr3");
      run_frame(16'hE001, 4, 0, "strm_rd");
      wdat[0] = 8'h5A;
      run_frame(16'h0033, 0, 5, "abort");
      wdat[0] = 8'hC3;
      run_frame(16'h0033, 1, 0, "post_abort");

      // Reset in the middle of a read, released with csb still low
      half = 6;
      csb  = 1'b0;
      repeat (half) @(negedge clk);
      instr = 16'h8014;
      for (int i = 15; i >= 0; i--) bit_xfer(instr[i], q, qoe);
      for (int i = 0; i < 3; i++) bit_xfer(1'b0, q, qoe);
      wr0 = wr_q.size(); rd0 = rd_q.size(); err0 = err_cnt;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst oe", sdio_oe, 0);
      check("midrst busy", busy, 0);
      rst_n = 1'b1;
      oe0 = oe_seen;
      for (int i = 0; i < 10; i++) bit_xfer(1'b1, q, qoe);
      check("midrst oe_after", oe_seen - oe0, 0);
      check("midrst busy_after", busy, 0);
      check("midrst wr", wr_q.size() - wr0, 0);
      check("midrst rd", rd_q.size() - rd0, 0);
      check("midrst err", err_cnt - err0, 0);
      csb = 1'b1;
      repeat (8) @(negedge clk);
      wdat[0] = 8'h7E;
      run_frame(16'h0010, 1, 0, "post_rst");

      // Random frames across all W codes, directions, lengths and mid-byte aborts
      for (int f = 0; f < 12; f++) begin
         instr = {1'($urandom), 2'($urandom), 13'($urandom)};
         nb    = $urandom_range(1, 4);
         ab    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
         for (int i = 0; i < 8; i++) wdat[i] = 8'($urandom);
         run_frame(instr, nb, ab, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
